// File: rtl/mdu_pkg.sv
// mdu_pkg: md_op encodings, default latencies and HI/LO read selects for the E-stage MDU.
package mdu_pkg;
    typedef enum logic [2:0] {
        MD_MULT  = 3'b000,
        MD_MULTU = 3'b001,
        MD_DIV   = 3'b010,
        MD_DIVU  = 3'b011,
        MD_MTHI  = 3'b100,
        MD_MTLO  = 3'b101
    } md_op_e;
    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;
    localparam logic HILO_LO = 1'b0;
    localparam logic HILO_HI = 1'b1;
endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: combinational {HI,LO} result for MULT/MULTU/DIV/DIVU.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [2:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] res,
    output logic        res_ok
);
    logic        sgn;
    logic [63:0] prod;
    logic [31:0] mag_a, mag_b, quo_u, rem_u, quo, rem;
    assign sgn   = (md_op == MD_MULT) || (md_op == MD_DIV);
    assign prod  = {{32{sgn & a[31]}}, a} * {{32{sgn & b[31]}}, b};
    // Signed divide runs on magnitudes so MIN_INT / -1 wraps to MIN_INT instead of trapping.
    assign mag_a = (sgn && a[31]) ? -a : a;
    assign mag_b = (b == '0) ? 32'd1 : (sgn && b[31]) ? -b : b;
    assign quo_u = mag_a / mag_b;
    assign rem_u = mag_a % mag_b;
    assign quo   = (sgn && (a[31] ^ b[31])) ? -quo_u : quo_u;
    assign rem   = (sgn && a[31]) ? -rem_u : rem_u;
    assign res   = (md_op == MD_MULT || md_op == MD_MULTU) ? prod : {rem, quo};
    assign res_ok = (md_op == MD_MULT || md_op == MD_MULTU) ||
                    ((md_op == MD_DIV || md_op == MD_DIVU) && b != '0);
endmodule

// File: rtl/mdu_exec.sv
// mdu_exec: E-stage multiply/divide unit owning HI/LO, with a busy countdown modelling latency.
module mdu_exec
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic        hilo_we,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        hilo_rd,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDU_Out
);
    localparam int CW = $clog2((MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1);
    logic [CW-1:0] cnt;
    logic [63:0]   res, pend;
    logic          res_ok, pend_ok, is_mul, is_div, accept;
    mdu_arith u_arith (.md_op(md_op), .a(A), .b(B), .res(res), .res_ok(res_ok));
    assign is_mul  = (md_op == MD_MULT) || (md_op == MD_MULTU);
    assign is_div  = (md_op == MD_DIV) || (md_op == MD_DIVU);
    assign accept  = start && !busy && (is_mul || is_div);
    assign MDU_Out = (hilo_rd == HILO_HI) ? HI : LO;
    always_ff @(posedge clk) begin
        if (reset) begin
            HI      <= '0;
            LO      <= '0;
            busy    <= 1'b0;
            cnt     <= '0;
            pend    <= '0;
            pend_ok <= 1'b0;
        end else if (accept) begin
            pend    <= res;
            pend_ok <= res_ok;
            cnt     <= is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
            busy    <= 1'b1;
        end else if (busy) begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
                busy <= 1'b0;
                if (pend_ok) {HI, LO} <= pend;
            end
        end else if (hilo_we && !start) begin
            if (md_op == MD_MTHI) HI <= A;
            if (md_op == MD_MTLO) LO <= A;
        end
    end
endmodule

// File: tb/tb_mdu_exec.sv
// tb_mdu_exec: directed checks of latency, arithmetic, MTHI/MTLO, ignored inputs and reset abort.
module tb_mdu_exec;
    logic        clk = 1'b0, reset = 1'b1, start = 1'b0, hilo_we = 1'b0, hilo_rd = 1'b0;
    logic [2:0]  md_op = 3'b000;
    logic [31:0] A = '0, B = '0;
    logic        busy;
    logic [31:0] HI, LO, MDU_Out;
    int          total = 0, passed = 0, n;

    mdu_exec dut (.clk(clk), .reset(reset), .start(start), .md_op(md_op), .hilo_we(hilo_we),
                  .A(A), .B(B), .hilo_rd(hilo_rd), .busy(busy), .HI(HI), .LO(LO), .MDU_Out(MDU_Out));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Issues one MD op, checks it was accepted, and returns the number of busy cycles seen.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int cycles);
        start = 1'b1; md_op = op; A = a; B = b;
        tick();
        start = 1'b0;
        check("accept", {31'b0, busy}, 32'd1);
        cycles = 0;
        while (busy && cycles < 50) begin
            cycles++;
            tick();
        end
    endtask

    initial begin
        tick(); tick();
        reset = 1'b0;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_hi", HI, 32'd0);
        check("rst_lo", LO, 32'd0);
        check("rst_out", MDU_Out, 32'd0);

        run_op(3'b000, 32'hFFFFFFFE, 32'd3, n);
        check("mult_len", n, 32'd5);
        check("mult_hi", HI, 32'hFFFFFFFF);
        check("mult_lo", LO, 32'hFFFFFFFA);
        hilo_rd = 1'b1; #1;
        check("out_hi", MDU_Out, 32'hFFFFFFFF);
        hilo_rd = 1'b0; #1;
        check("out_lo", MDU_Out, 32'hFFFFFFFA);

        run_op(3'b011, 32'd100, 32'd7, n);
        check("divu_len", n, 32'd10);
        check("divu_lo", LO, 32'd14);
        check("divu_hi", HI, 32'd2);

        run_op(3'b010, 32'hFFFFFFF9, 32'd2, n);
        check("div_lo", LO, 32'hFFFFFFFD);
        check("div_hi", HI, 32'hFFFFFFFF);

        run_op(3'b010, 32'h80000000, 32'hFFFFFFFF, n);
        check("ovf_lo", LO, 32'h80000000);
        check("ovf_hi", HI, 32'd0);

        hilo_we = 1'b1; md_op = 3'b100; A = 32'h11111111;
        tick();
        check("mthi", HI, 32'h11111111);
        md_op = 3'b101; A = 32'h22222222;
        tick();
        hilo_we = 1'b0;
        check("mtlo", LO, 32'h22222222);
        check("mt_busy", {31'b0, busy}, 32'd0);
        run_op(3'b010, 32'd55, 32'd0, n);
        check("dz_len", n, 32'd10);
        check("dz_hi", HI, 32'h11111111);
        check("dz_lo", LO, 32'h22222222);

        start = 1'b1; md_op = 3'b111; A = 32'd9; B = 32'd9;
        tick();
        start = 1'b0;
        check("undef_busy", {31'b0, busy}, 32'd0);

        start = 1'b1; md_op = 3'b000; A = 32'd2; B = 32'd3;
        tick();
        start = 1'b0;
        n = 0;
        while (busy && n < 50) begin
            n++;
            if (n == 2) begin
                start = 1'b1; md_op = 3'b011; A = 32'h0000DEAD; B = 32'd1;
            end else if (n == 3) begin
                start = 1'b0; hilo_we = 1'b1; md_op = 3'b100;
            end else begin
                start = 1'b0; hilo_we = 1'b0;
            end
            tick();
        end
        start = 1'b0; hilo_we = 1'b0;
        check("ign_len", n, 32'd5);
        check("ign_hi", HI, 32'd0);
        check("ign_lo", LO, 32'd6);

        start = 1'b1; md_op = 3'b010; A = 32'd100; B = 32'd3;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_hi", HI, 32'd0);
        check("abort_lo", LO, 32'd0);
        repeat (12) tick();
        check("nocommit_hi", HI, 32'd0);
        check("nocommit_lo", LO, 32'd0);

        hilo_we = 1'b1; md_op = 3'b101; A = 32'd5;
        tick();
        hilo_we = 1'b0;
        check("mtlo5", LO, 32'd5);
        check("mtlo5_busy", {31'b0, busy}, 32'd0);

        run_op(3'b000, 32'd3, 32'd4, n);
        check("b2b1_lo", LO, 32'd12);
        run_op(3'b001, 32'hFFFFFFFF, 32'd2, n);
        check("b2b2_len", n, 32'd5);
        check("b2b2_hi", HI, 32'd1);
        check("b2b2_lo", LO, 32'hFFFFFFFE);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
